row_writer: RTL and testbench
=============================

Name: row_writer

Overview:
- Hardware-side writer for the bench's row-text format: accepts a packed word of NUM_FIELDS fields and emits one ASCII text row. Each field is written as binary digits, fields are separated by single spaces, and the row ends with a newline.
- Output is a valid/ready byte stream, so a DUT or trace path can produce rows that the bench's row parsers consume field by field.
- Sits between a capture source, such as a DUT probe, and a byte sink, such as a UART, FIFO or simulation file-dump model.

Parameters:
- FIELD_WIDTH, 8, bits per field (>=1).
- NUM_FIELDS, 4, fields per row (>=1).
- COUNT_WIDTH, 16, width of the completed-row counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  row word offered.
- in_ready  out  1  writer can accept a row word.
- in_data  in  NUM_FIELDS*FIELD_WIDTH  packed fields; field 0 = in_data[NUM_FIELDS*FIELD_WIDTH-1 -: FIELD_WIDTH], written first.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  sink accepts out_byte.
- out_byte  out  8  ASCII byte: 0x30 '0', 0x31 '1', 0x20 ' ', 0x0A '\n'.
- busy  out  1  row in progress (not IDLE).
- rows_done  out  COUNT_WIDTH  count of fully emitted rows.

Behaviour:
- Reset (async assert, sync release to IDLE):
  - in_ready=1 (after the first clk edge, or combinationally from IDLE).
  - out_valid=0, out_byte=0x00, busy=0, rows_done=0.
  - Internal shift register and counters are cleared.
- Input handshake:
  - in_ready = (state==IDLE).
  - A word is accepted on a rising edge with in_valid&&in_ready; in_data is latched into the shift register.
  - in_data is ignored at all other times.
- FSM states: IDLE, BIT, SEP, EOL.
  - IDLE -> BIT on accept.
  - BIT: out_byte = 0x30 + current MSB of the shift register. On out handshake, shift left by 1 and increment the bit index.
    - When the last bit of a field handshakes: go to SEP if the field index < NUM_FIELDS-1, else EOL.
  - SEP: out_byte=0x20. On handshake -> BIT, field index +1, bit index 0.
  - EOL: out_byte=0x0A. On handshake -> IDLE, rows_done+1.
- Output registering:
  - out_valid=1 in BIT/SEP/EOL, 0 in IDLE.
  - out_byte and out_valid are registered and must hold stable while out_valid&&!out_ready.
  - The state advances only on out_valid&&out_ready.
- Latency and throughput:
  - The first byte is valid the cycle after input accept.
  - Bytes per row = NUM_FIELDS*(FIELD_WIDTH+1).
  - With out_ready held high, a row occupies exactly that many cycles of out_valid, followed by one IDLE cycle before the next accept.
  - Minimum row period = bytes+1 cycles.
- NUM_FIELDS=1: SEP is never entered; the last bit goes straight to EOL.
- rows_done wraps modulo 2^COUNT_WIDTH.
- busy = state!=IDLE.
- Reset mid-row: the row is abandoned immediately. out_valid drops asynchronously and no partial newline is emitted. rows_done=0.
- out_ready high while out_valid=0 has no effect.
- in_valid high while busy has no effect, and the word is not latched.
- Counters are sized ceil(log2) of FIELD_WIDTH and NUM_FIELDS, minimum 1 bit.

Test Plan:
- FIELD_WIDTH=4, NUM_FIELDS=2, in_data=8'hA5, out_ready=1 -> bytes 31 30 31 30 20 30 31 30 31 0A on 10 consecutive cycles starting the cycle after accept. rows_done=1, then in_ready=1.
- Same word, out_ready toggled 1,0,0,1,... (random stalls) -> identical 10-byte sequence. out_byte is stable through every stall, and no byte is duplicated or dropped.
- Back-to-back words 8'hFF then 8'h00, in_valid held high -> "1111 1111\n0000 0000\n". Second accept only in the IDLE cycle; 21 cycles total from the first accept to the last byte. rows_done=2.
- NUM_FIELDS=1, FIELD_WIDTH=3, in_data=3'b011 -> 30 31 31 0A with no 0x20 byte.
- Assert rst after the 4th byte of an 8'hA5 row -> out_valid=0 in the same cycle, no further bytes, rows_done=0, busy=0. Then a fresh row emits correctly from its first bit.
- COUNT_WIDTH=2, four rows emitted -> rows_done steps 1,2,3,0.

Source files
------------

// File: rtl/row_writer.sv
// Streams a packed row word as ASCII binary text:
// fields separated by spaces, row ended by a newline.
module row_writer #(
  parameter int FIELD_WIDTH = 8,
  parameter int NUM_FIELDS  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        out_byte,
  output logic                              busy,
  output logic [COUNT_WIDTH-1:0]            rows_done
);

  localparam int W  = NUM_FIELDS * FIELD_WIDTH;
  localparam int BW = (FIELD_WIDTH > 1) ? $clog2(FIELD_WIDTH) : 1;
  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FIELD_WIDTH - 1);
  localparam logic [FW-1:0] LAST_FLD = FW'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    SEP,
    EOL
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           sr_q, sr_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [FW-1:0]          fld_q, fld_d;
  logic [7:0]             byte_q, byte_d;
  logic [COUNT_WIDTH-1:0] rows_q, rows_d;
  logic                   hs;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign out_byte  = byte_q;
  assign rows_done = rows_q;
  assign hs        = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      fld_q   <= '0;
      byte_q  <= 8'h00;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      fld_q   <= fld_d;
      byte_q  <= byte_d;
      rows_q  <= rows_d;
    end
  end

  // byte_d is the byte presented while in state_d, so
  // out_byte comes straight from a register.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    fld_d   = fld_q;
    byte_d  = byte_q;
    rows_d  = rows_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BIT;
          sr_d    = in_data;
          bit_d   = '0;
          fld_d   = '0;
          byte_d  = {7'h18, in_data[W-1]};
        end
      end
      BIT: begin
        if (hs) begin
          sr_d = sr_q << 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (fld_q == LAST_FLD) begin
              state_d = EOL;
              byte_d  = 8'h0A;
            end else begin
              state_d = SEP;
              byte_d  = 8'h20;
            end
          end else begin
            bit_d  = bit_q + BW'(1);
            byte_d = {7'h18, sr_d[W-1]};
          end
        end
      end
      SEP: begin
        if (hs) begin
          state_d = BIT;
          fld_d   = fld_q + FW'(1);
          bit_d   = '0;
          byte_d  = {7'h18, sr_q[W-1]};
        end
      end
      EOL: begin
        if (hs) begin
          state_d = IDLE;
          rows_d  = rows_q + COUNT_WIDTH'(1);
          byte_d  = 8'h00;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_row_writer.sv
// Directed bench for row_writer: three instances cover
// the default-style row, a single-field row and counter wrap.
module tb_row_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // instance A: FIELD_WIDTH=4, NUM_FIELDS=2
  logic        a_in_valid = 1'b0, a_in_ready;
  logic [7:0]  a_in_data = '0;
  logic        a_out_valid, a_out_ready = 1'b1;
  logic [7:0]  a_out_byte;
  logic        a_busy;
  logic [15:0] a_rows;

  row_writer #(.FIELD_WIDTH(4), .NUM_FIELDS(2), .COUNT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_byte(a_out_byte), .busy(a_busy), .rows_done(a_rows)
  );

  // instance B: FIELD_WIDTH=3, NUM_FIELDS=1
  logic        b_in_valid = 1'b0, b_in_ready;
  logic [2:0]  b_in_data = '0;
  logic        b_out_valid, b_out_ready = 1'b1;
  logic [7:0]  b_out_byte;
  logic        b_busy;
  logic [15:0] b_rows;

  row_writer #(.FIELD_WIDTH(3), .NUM_FIELDS(1), .COUNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_byte(b_out_byte), .busy(b_busy), .rows_done(b_rows)
  );

  // instance C: 2-bit row counter
  logic        c_in_valid = 1'b0, c_in_ready;
  logic [7:0]  c_in_data = '0;
  logic        c_out_valid, c_out_ready = 1'b1;
  logic [7:0]  c_out_byte;
  logic        c_busy;
  logic [1:0]  c_rows;

  row_writer #(.FIELD_WIDTH(4), .NUM_FIELDS(2), .COUNT_WIDTH(2)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_byte(c_out_byte), .busy(c_busy), .rows_done(c_rows)
  );

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  int         a_t[$];
  int         a_acc[$];
  int         cyc = 0;
  logic       a_stall = 1'b0;
  logic [7:0] a_prev = '0;

  always @(posedge clk) begin
    if (a_stall)
      chk("stall_hold", {23'b0, a_out_valid, a_out_byte},
          {23'b0, 1'b1, a_prev});
    a_stall <= a_out_valid && !a_out_ready;
    a_prev  <= a_out_byte;
    if (a_out_valid && a_out_ready) begin
      a_q.push_back(a_out_byte);
      a_t.push_back(cyc);
    end
    if (a_in_valid && a_in_ready) a_acc.push_back(cyc);
    if (b_out_valid && b_out_ready) b_q.push_back(b_out_byte);
    cyc <= cyc + 1;
  end

  task automatic chk_row(input string tag, input logic [7:0] q[$],
                         input string exp);
    chk({tag, "_len"}, 32'(q.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < q.size(); i++)
      chk(tag, 32'(q[i]), 32'(exp[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    a_q.delete(); a_t.delete(); a_acc.delete(); b_q.delete();
  endtask

  task automatic a_run(input logic [7:0] d, input bit stall);
    logic [0:7]  pat;
    logic [15:0] r0;
    int          n;
    pat = 8'b10011010;
    r0 = a_rows;
    n = a_acc.size();
    a_in_data = d;
    a_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a_out_ready = stall ? pat[i % 8] : 1'b1;
      @(posedge clk);
      #1;
      if (a_acc.size() > n) a_in_valid = 1'b0;
      if (a_rows != r0) break;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_byte", 32'(a_out_byte), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_rows", 32'(a_rows), 0);
    do_reset();
    chk("rst_in_ready", 32'(a_in_ready), 1);

    a_run(8'hA5, 1'b0);
    chk_row("row_a5", a_q, "1010 0101\n");
    if (a_acc.size() > 0 && a_t.size() == 10) begin
      chk("first_lat", 32'(a_t[0] - a_acc[0]), 1);
      chk("row_span", 32'(a_t[9] - a_acc[0]), 10);
    end else begin
      chk("row_a5_acc", 32'(a_acc.size()), 1);
    end
    chk("rows_after1", 32'(a_rows), 1);
    chk("ready_after1", 32'(a_in_ready), 1);

    a_q.delete(); a_t.delete();
    a_run(8'hA5, 1'b1);
    chk_row("row_stall", a_q, "1010 0101\n");
    chk("rows_after2", 32'(a_rows), 2);

    do_reset();
    a_in_data = 8'hFF;
    a_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (a_acc.size() == 1) a_in_data = 8'h00;
      if (a_acc.size() >= 2) a_in_valid = 1'b0;
      if (a_rows == 16'd2) break;
    end
    a_in_valid = 1'b0;
    chk_row("b2b", a_q, "1111 1111\n0000 0000\n");
    if (a_acc.size() == 2 && a_t.size() == 20) begin
      chk("b2b_gap", 32'(a_acc[1] - a_acc[0]), 11);
      chk("b2b_span", 32'(a_t[19] - a_acc[0]), 21);
    end else begin
      chk("b2b_acc", 32'(a_acc.size()), 2);
    end
    chk("b2b_rows", 32'(a_rows), 2);

    do_reset();
    a_in_data = 8'hA5;
    a_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (a_acc.size() >= 1) a_in_valid = 1'b0;
      if (a_q.size() >= 4) break;
    end
    a_in_valid = 1'b0;
    chk("mid_bytes", 32'(a_q.size()), 4);
    chk("mid_valid_pre", 32'(a_out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(a_out_valid), 0);
    chk("mid_busy", 32'(a_busy), 0);
    chk("mid_rows", 32'(a_rows), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_more", 32'(a_q.size()), 4);
    a_q.delete(); a_t.delete();
    a_run(8'hA5, 1'b0);
    chk_row("after_rst", a_q, "1010 0101\n");
    chk("after_rst_rows", 32'(a_rows), 1);

    b_in_data = 3'b011;
    b_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      if (b_rows == 16'd1) break;
    end
    chk_row("nf1", b_q, "011\n");

    do_reset();
    for (int k = 0; k < 4; k++) begin
      c_in_data = 8'(k * 17);
      c_in_valid = 1'b1;
      @(posedge clk);
      #1;
      c_in_valid = 1'b0;
      for (int i = 0; i < 50 && c_busy; i++) begin
        @(posedge clk);
        #1;
      end
      chk("wrap_rows", 32'(c_rows), 32'((k + 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
